// File: rtl/pipe_ctrl_gen_if.sv
// Pipeline control bus: stall requests and exception info in, stall mask and redirect out.
// The master side is the pipeline; the slave side is the controller.
interface pipe_ctrl_gen_if #(
    parameter int unsigned STAGES = 6,
    parameter int unsigned CNT_W  = 32
);
    logic [STAGES-1:0] stallreq_i;
    logic [31:0]       excepttype_i;
    logic [2:0]        int_id_i;
    logic [31:0]       cp0_epc_i;
    logic              ebase_we_i;
    logic [31:0]       ebase_i;
    logic              vec_mode_i;
    logic              perf_clr_i;
    logic [31:0]       new_pc;
    logic              flush;
    logic [STAGES-1:0] stall;
    logic              timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output stallreq_i, excepttype_i, int_id_i, cp0_epc_i, ebase_we_i, ebase_i,
               vec_mode_i, perf_clr_i,
        input  new_pc, flush, stall, timeout_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_i, excepttype_i, int_id_i, cp0_epc_i, ebase_we_i, ebase_i,
               vec_mode_i, perf_clr_i,
        output new_pc, flush, stall, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control unit: per-stage stall masks, flush window, exception redirect PC,
// stall watchdog and saturating stall-cycle counter.
module pipe_ctrl_gen #(
    parameter int unsigned STAGES    = 6,
    parameter int unsigned FLUSH_LEN = 1,
    parameter logic [31:0] EBASE_RST = 32'h0000_0000,
    parameter int unsigned WDT_LIMIT = 1024,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned VEC_SHIFT = 5
) (
    input logic            clk,
    input logic            rst,
    pipe_ctrl_gen_if.slave bus
);

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic [31:0] EXC_INT  = 32'h0000_000f;
    localparam int unsigned WDT_W    = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
    localparam logic [WDT_W-1:0] WDT_TOP = (WDT_LIMIT > 0) ? WDT_W'(WDT_LIMIT - 1) : '0;
    localparam int unsigned IF_IDX   = (STAGES > 2) ? 1 : 0;
    localparam int unsigned ID_IDX   = (STAGES > 3) ? 2 : IF_IDX;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e            state;
    logic [3:0]        fcnt;
    logic [31:0]       ebase;
    logic [WDT_W-1:0]  wdt_cnt;
    logic [CNT_W-1:0]  perf_cnt;

    logic [STAGES-1:0] req_mask;
    logic [STAGES-1:0] stall_c;
    logic              flush_c;
    logic [31:0]       pc_c;
    logic [31:0]       vec_off;
    logic              exc;
    logic              stalled;
    logic              wdt_hit;
    logic              any_req;
    logic              unused_bits;

    assign unused_bits = ^{bus.stallreq_i[STAGES-1], bus.ebase_i[11:0]};
    assign exc         = (bus.excepttype_i != 32'h0);
    assign vec_off     = 32'(bus.int_id_i) << VEC_SHIFT;

    // Thermometer mask from the highest requesting stage down to PC; WB request is ignored.
    always_comb begin
        req_mask = '0;
        any_req  = 1'b0;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            any_req     = any_req | bus.stallreq_i[i];
            req_mask[i] = any_req;
        end
        // An IF stall must also hold ID so the instruction in decode is not lost.
        if (STAGES > 2 && bus.stallreq_i[IF_IDX]) begin
            req_mask[ID_IDX] = 1'b1;
        end
    end

    always_comb begin
        stall_c = '0;
        flush_c = 1'b0;
        pc_c    = 32'h0;
        if (!rst) begin
            stall_c = '1;
        end else if (state == StFlush) begin
            flush_c = 1'b1;
        end else if (exc) begin
            flush_c = 1'b1;
            case (bus.excepttype_i)
                EXC_ERET: pc_c = bus.cp0_epc_i;
                EXC_INT:  pc_c = bus.vec_mode_i ? (ebase + 32'h200 + vec_off)
                                                : (ebase + 32'h20);
                default:  pc_c = ebase + 32'h40;
            endcase
        end else begin
            stall_c = req_mask;
        end
    end

    assign stalled = rst && (state == StIdle) && !exc && (|req_mask);
    assign wdt_hit = (WDT_LIMIT != 0) && stalled && (wdt_cnt == WDT_TOP);

    assign bus.stall       = stall_c;
    assign bus.flush       = flush_c;
    assign bus.new_pc      = pc_c;
    assign bus.timeout_o   = wdt_hit;
    assign bus.stall_cnt_o = perf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            fcnt     <= 4'd0;
            ebase    <= EBASE_RST;
            wdt_cnt  <= '0;
            perf_cnt <= '0;
        end else begin
            if (bus.ebase_we_i) begin
                ebase <= {bus.ebase_i[31:12], 12'h000};
            end

            case (state)
                StIdle: begin
                    if (exc && FLUSH_LEN > 1) begin
                        state <= StFlush;
                        fcnt  <= 4'(FLUSH_LEN - 1);
                    end
                end
                StFlush: begin
                    if (fcnt <= 4'd1) begin
                        state <= StIdle;
                    end else begin
                        fcnt <= fcnt - 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (!stalled || wdt_hit) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end

            if (bus.perf_clr_i) begin
                perf_cnt <= '0;
            end else if (stalled && perf_cnt != '1) begin
                perf_cnt <= perf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: one default instance and one with a 3-cycle flush
// window and a 4-cycle watchdog.
module tb_pipe_ctrl_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_gen_if #(.STAGES(6), .CNT_W(32)) a_if ();
    pipe_ctrl_gen_if #(.STAGES(6), .CNT_W(32)) b_if ();

    pipe_ctrl_gen u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    pipe_ctrl_gen #(
        .FLUSH_LEN (3),
        .WDT_LIMIT (4)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        bit          sel;
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Side inputs applied by cyc() alongside the per-call stimulus.
    logic        rst_v = 1'b0;
    logic [31:0] epc_v = 32'h0;
    logic [31:0] eb_v  = 32'h0;
    logic [2:0]  iid_v = 3'd0;
    logic        vm_v  = 1'b0;
    logic        we_v  = 1'b0;
    logic        clr_v = 1'b0;

    task automatic chk(input string name, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input logic [5:0] st, input logic fl,
                           input logic [31:0] pc, input logic to, input logic [31:0] cnt);
        chk(e.name, "stall", 32'(st), 32'(e.stall));
        chk(e.name, "flush", 32'(fl), 32'(e.flush));
        chk(e.name, "new_pc", pc, e.pc);
        chk(e.name, "timeout", 32'(to), 32'(e.to));
        chk(e.name, "stall_cnt", cnt, e.cnt);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.sel) begin
                compare(mon_e, b_if.stall, b_if.flush, b_if.new_pc, b_if.timeout_o,
                        b_if.stall_cnt_o);
            end else begin
                compare(mon_e, a_if.stall, a_if.flush, a_if.new_pc, a_if.timeout_o,
                        a_if.stall_cnt_o);
            end
        end
    end

    task automatic cyc(input bit sel, input string name, input logic [5:0] req,
                       input logic [31:0] exc, input logic [5:0] st, input logic fl,
                       input logic [31:0] pc, input logic to, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rst_v;
        if (sel) begin
            b_if.stallreq_i = req;   b_if.excepttype_i = exc; b_if.cp0_epc_i = epc_v;
            b_if.int_id_i = iid_v;   b_if.vec_mode_i = vm_v;  b_if.ebase_we_i = we_v;
            b_if.ebase_i = eb_v;     b_if.perf_clr_i = clr_v;
        end else begin
            a_if.stallreq_i = req;   a_if.excepttype_i = exc; a_if.cp0_epc_i = epc_v;
            a_if.int_id_i = iid_v;   a_if.vec_mode_i = vm_v;  a_if.ebase_we_i = we_v;
            a_if.ebase_i = eb_v;     a_if.perf_clr_i = clr_v;
        end
        e.sel = sel; e.name = name; e.stall = st; e.flush = fl;
        e.pc = pc;   e.to = to;     e.cnt = cnt;
        sb.push_back(e);
    endtask

    initial begin
        a_if.stallreq_i = '0; a_if.excepttype_i = '0; a_if.cp0_epc_i = '0; a_if.int_id_i = '0;
        a_if.vec_mode_i = 0;  a_if.ebase_we_i = 0;    a_if.ebase_i = '0;   a_if.perf_clr_i = 0;
        b_if.stallreq_i = '0; b_if.excepttype_i = '0; b_if.cp0_epc_i = '0; b_if.int_id_i = '0;
        b_if.vec_mode_i = 0;  b_if.ebase_we_i = 0;    b_if.ebase_i = '0;   b_if.perf_clr_i = 0;

        // Reset and basic stall masks on the default instance.
        cyc(0, "rst_a", 6'h00, 32'h0, 6'h3f, 0, 32'h0, 0, 0);
        cyc(1, "rst_b", 6'h00, 32'h0, 6'h3f, 0, 32'h0, 0, 0);
        rst_v = 1'b1;
        cyc(0, "idle", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 0);
        cyc(0, "mem_stall", 6'b001000, 32'h0, 6'b001111, 0, 32'h0, 0, 0);
        cyc(0, "if_stall", 6'b000010, 32'h0, 6'b000111, 0, 32'h0, 0, 1);
        cyc(0, "cnt2", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 2);

        // EBASE and exception vectors.
        we_v = 1'b1; eb_v = 32'h8000_0123;
        cyc(0, "ebase_wr", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 2);
        we_v = 1'b0;
        cyc(0, "exc_08", 6'h00, 32'h08, 6'h00, 1, 32'h8000_0040, 0, 2);
        epc_v = 32'h0000_1234;
        cyc(0, "eret", 6'h00, 32'h0e, 6'h00, 1, 32'h0000_1234, 0, 2);
        epc_v = 32'h0;
        cyc(0, "int_nonvec", 6'h00, 32'h0f, 6'h00, 1, 32'h8000_0020, 0, 2);
        vm_v = 1'b1; iid_v = 3'd3;
        cyc(0, "int_vec_hi", 6'h00, 32'h0f, 6'h00, 1, 32'h8000_0260, 0, 2);
        we_v = 1'b1; eb_v = 32'h0;
        cyc(0, "ebase_clr", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 2);
        we_v = 1'b0;
        cyc(0, "int_vec3", 6'h00, 32'h0f, 6'h00, 1, 32'h0000_0260, 0, 2);
        iid_v = 3'd7;
        cyc(0, "int_vec7", 6'h00, 32'h0f, 6'h00, 1, 32'h0000_02e0, 0, 2);
        iid_v = 3'd0; vm_v = 1'b0;
        cyc(0, "exc_01", 6'h00, 32'h01, 6'h00, 1, 32'h0000_0040, 0, 2);
        cyc(0, "exc_over_stall", 6'b001000, 32'h17, 6'h00, 1, 32'h0000_0040, 0, 2);

        // Mask boundaries and counter clear.
        cyc(0, "req_all", 6'h3f, 32'h0, 6'b011111, 0, 32'h0, 0, 2);
        cyc(0, "req_wb_only", 6'b100000, 32'h0, 6'h00, 0, 32'h0, 0, 3);
        cyc(0, "req_pc", 6'b000001, 32'h0, 6'b000001, 0, 32'h0, 0, 3);
        clr_v = 1'b1;
        cyc(0, "perf_clr", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 4);
        clr_v = 1'b0;
        cyc(0, "cnt_zero", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 0);

        // Flush window: exception plus two FLUSH cycles that ignore requests and exceptions.
        cyc(1, "b_exc", 6'h00, 32'h08, 6'h00, 1, 32'h0000_0040, 0, 0);
        epc_v = 32'h0000_1234;
        cyc(1, "b_flush1", 6'b000100, 32'h0e, 6'h00, 1, 32'h0, 0, 0);
        epc_v = 32'h0;
        cyc(1, "b_flush2", 6'b000100, 32'h0, 6'h00, 1, 32'h0, 0, 0);

        // Watchdog pulses on the 4th and 8th consecutive stalled cycles.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, "b_wdt", 6'b000100, 32'h0, 6'b000111, 0, 32'h0, (i % 4) == 0, 32'(i - 1));
        end
        clr_v = 1'b1;
        cyc(1, "b_clr", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 8);
        clr_v = 1'b0;
        cyc(1, "b_cnt0", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 0);

        // A non-stalled cycle restarts the watchdog count.
        cyc(1, "b_stall1", 6'b000100, 32'h0, 6'b000111, 0, 32'h0, 0, 0);
        cyc(1, "b_gap", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, "b_wdt_rst", 6'b000100, 32'h0, 6'b000111, 0, 32'h0, i == 4, 32'(i));
        end

        // Reset in the middle of a flush window returns straight to IDLE.
        cyc(1, "b_exc2", 6'h00, 32'h08, 6'h00, 1, 32'h0000_0040, 0, 5);
        cyc(1, "b_flush_a", 6'h00, 32'h0, 6'h00, 1, 32'h0, 0, 5);
        rst_v = 1'b0;
        cyc(1, "b_rst_mid", 6'h00, 32'h0, 6'h3f, 0, 32'h0, 0, 0);
        rst_v = 1'b1;
        cyc(1, "b_after_rst", 6'h00, 32'h0, 6'h00, 0, 32'h0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
